// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional perf counters in fetch_unit are enabled by defining FETCH_PERF_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard-unit controls, ID redirects, instruction memory and IF/ID outputs.
interface fetch_unit_if;
  logic        pc_write_enable;
  logic        ifid_write_enable;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  modport master (
    input  pc_write_enable, ifid_write_enable, branch, branch_target,
           jump, jump_target, imem_data,
    output imem_addr, id_instruction, id_pc_plus4, id_valid
  );

  modport slave (
    output pc_write_enable, ifid_write_enable, branch, branch_target,
           jump, jump_target, imem_data,
    input  imem_addr, id_instruction, id_pc_plus4, id_valid
  );
endinterface

// File: rtl/fetch_unit_if_id_register.sv
// IF/ID pipeline register: holds when write is disabled, loads a NOP bubble on squash.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = FETCH_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic        squash,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  logic [31:0] instr_reg;
  logic [31:0] pc_plus4_reg;
  logic        valid_reg;

  // Hold has priority over squash so a stalled ID stage keeps its instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg    <= NOP_WORD;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (write_en) begin
      instr_reg    <= squash ? NOP_WORD : instr;
      pc_plus4_reg <= pc_plus4;
      valid_reg    <= ~squash;
    end
  end

  assign id_instruction = instr_reg;
  assign id_pc_plus4    = pc_plus4_reg;
  assign id_valid       = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select, fetch FSM and IF/ID register.
// Define FETCH_PERF_EN to build the stall/squash performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = FETCH_NOP
) (
  input  logic           clk,
  input  logic           reset,
  fetch_unit_if.master   fif,
  output logic [1:0]     fetch_state,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    squash_count
);

  logic [31:0]  pc_reg;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  fetch_state_t state_reg;
  fetch_state_t state_next;

  // A redirect without PC write permission is dropped.
  assign redirect = (fif.jump | fif.branch) & fif.pc_write_enable;
  assign target   = word_align(fif.jump ? fif.jump_target : fif.branch_target);
  assign pc_plus4 = pc_reg + PC_INCR;

  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = target;
    end else if (fif.pc_write_enable) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign fif.imem_addr = pc_reg;

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk            (clk),
    .reset          (reset),
    .write_en       (fif.ifid_write_enable),
    .squash         (redirect),
    .instr          (fif.imem_data),
    .pc_plus4       (pc_plus4),
    .id_instruction (fif.id_instruction),
    .id_pc_plus4    (fif.id_pc_plus4),
    .id_valid       (fif.id_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // The current state never feeds back, so an illegal encoding recovers in one edge.
  always_comb begin
    state_next = RUN;
    if (redirect) begin
      state_next = SQUASH;
    end else if (!fif.pc_write_enable && !fif.ifid_write_enable) begin
      state_next = STALL;
    end
  end

  always_comb begin
    fetch_state = state_reg;
  end

`ifdef FETCH_PERF_EN
  logic [1:0] cnt_inc;
  assign cnt_inc = {redirect, (state_next == STALL)};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign stall_cycles = g_cnt[0].cnt_reg;
  assign squash_count = g_cnt[1].cnt_reg;
`else
  assign stall_cycles = '0;
  assign squash_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences and random
// stimulus against a behavioural model. Honours FETCH_PERF_EN for the counter checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  fetch_state;
  logic [31:0] stall_cycles;
  logic [31:0] squash_count;

  fetch_unit_if fif ();

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .fif          (fif),
    .fetch_state  (fetch_state),
    .stall_cycles (stall_cycles),
    .squash_count (squash_count)
  );

  always #5 clk = ~clk;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction

  assign fif.imem_data = mem_word(fif.imem_addr);

  // The hazard unit must never present a redirect while holding the PC.
  always @(posedge clk) begin
    if (!reset && !fif.pc_write_enable)
      assert (!(fif.branch || fif.jump))
      else $error("redirect presented while pc_write_enable is low");
  end

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model state
  logic [31:0] m_pc, m_inst, m_pc4, m_stall, m_squash;
  logic        m_valid;
  logic [1:0]  m_state;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt, inc;
    if (reset) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_state = 2'd0; m_stall = 0; m_squash = 0;
    end else begin
      redir = (fif.branch || fif.jump) && fif.pc_write_enable;
      tgt   = fif.jump ? fif.jump_target : fif.branch_target;
      tgt   = (tgt / 4) * 4;
      inc   = m_pc + 32'd4;
      if (fif.ifid_write_enable) begin
        m_pc4   = inc;
        m_inst  = redir ? 32'h0 : mem_word(m_pc);
        m_valid = !redir;
      end
      if (redir) m_state = 2'd2;
      else if (!fif.pc_write_enable && !fif.ifid_write_enable) m_state = 2'd1;
      else m_state = 2'd0;
      if (m_state == 2'd1 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redir && m_squash != 32'hFFFF_FFFF) m_squash++;
      if (redir) m_pc = tgt;
      else if (fif.pc_write_enable) m_pc = inc;
    end
  endtask

  task automatic cycle(input bit rst, input bit pwe, input bit iwe,
                       input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input string tag);
    reset = rst;
    fif.pc_write_enable = pwe; fif.ifid_write_enable = iwe;
    fif.branch = br; fif.branch_target = bt;
    fif.jump = j; fif.jump_target = jt;
    @(posedge clk);
    model_edge();
    #1;
    txn++;
    $display("txn %0d %s rst=%0b pwe=%0b iwe=%0b br=%0b j=%0b pc=%h id=%h v=%0b st=%0d",
             txn, tag, rst, pwe, iwe, br, j, fif.imem_addr, fif.id_instruction,
             fif.id_valid, fetch_state);
    chk({tag, " pc"},     fif.imem_addr,      m_pc);
    chk({tag, " inst"},   fif.id_instruction, m_inst);
    chk({tag, " pc4"},    fif.id_pc_plus4,    m_pc4);
    chk({tag, " valid"},  {31'd0, fif.id_valid}, {31'd0, m_valid});
    chk({tag, " state"},  {30'd0, fetch_state}, {30'd0, m_state});
    chk({tag, " stalls"}, stall_cycles, PERF ? m_stall : 32'd0);
    chk({tag, " squash"}, squash_count, PERF ? m_squash : 32'd0);
  endtask

  task automatic run(input string tag);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, tag);
  endtask

  typedef struct {
    bit          rst, pwe, iwe, br;
    logic [31:0] bt;
    bit          j;
    logic [31:0] jt;
    logic [31:0] e_pc, e_inst, e_pc4;
    bit          e_valid;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vt[6];

  initial begin
    reset = 1'b1;
    fif.pc_write_enable = 1'b0; fif.ifid_write_enable = 1'b0;
    fif.branch = 1'b0; fif.branch_target = '0;
    fif.jump = 1'b0; fif.jump_target = '0;
    m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_state = 0; m_stall = 0; m_squash = 0;

    //        rst pwe iwe br  bt     j   jt    e_pc   e_inst          e_pc4  v  st
    vt[0] = '{1, 1, 1, 0, 32'h0,  0, 32'h0, 32'h00, 32'h0000_0000, 32'h00, 0, 2'd0};
    vt[1] = '{0, 1, 1, 0, 32'h0,  0, 32'h0, 32'h04, 32'h2000_0000, 32'h04, 1, 2'd0};
    vt[2] = '{0, 1, 1, 0, 32'h0,  0, 32'h0, 32'h08, 32'h2000_0004, 32'h08, 1, 2'd0};
    vt[3] = '{0, 1, 1, 0, 32'h0,  0, 32'h0, 32'h0C, 32'h2000_0008, 32'h0C, 1, 2'd0};
    vt[4] = '{0, 1, 1, 1, 32'h40, 0, 32'h0, 32'h40, 32'h0000_0000, 32'h10, 0, 2'd2};
    vt[5] = '{0, 1, 1, 0, 32'h0,  0, 32'h0, 32'h44, 32'h2000_0040, 32'h44, 1, 2'd0};

    for (int i = 0; i < 6; i++) begin
      cycle(vt[i].rst, vt[i].pwe, vt[i].iwe, vt[i].br, vt[i].bt, vt[i].j, vt[i].jt, "vec");
      chk("vec exp pc",    fif.imem_addr,      vt[i].e_pc);
      chk("vec exp inst",  fif.id_instruction, vt[i].e_inst);
      chk("vec exp pc4",   fif.id_pc_plus4,    vt[i].e_pc4);
      chk("vec exp valid", {31'd0, fif.id_valid}, {31'd0, vt[i].e_valid});
      chk("vec exp state", {30'd0, fetch_state}, {30'd0, vt[i].e_state});
    end

    // Three-cycle stall at PC=0x10
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "rst");
    for (int i = 0; i < 4; i++) run("run");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "stall");
      chk("stall pc",    fif.imem_addr,      32'h10);
      chk("stall inst",  fif.id_instruction, 32'h2000_000C);
      chk("stall pc4",   fif.id_pc_plus4,    32'h10);
      chk("stall state", {30'd0, fetch_state}, 32'd1);
    end
    chk("stall count", stall_cycles, PERF ? 32'd3 : 32'd0);

    // Reset asserted mid-stall at PC=0x24
    for (int i = 0; i < 5; i++) run("run");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "stall");
    chk("pre-reset pc", fif.imem_addr, 32'h24);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "rst");
    chk("rst pc",     fif.imem_addr, 32'h0);
    chk("rst valid",  {31'd0, fif.id_valid}, 32'd0);
    chk("rst state",  {30'd0, fetch_state}, 32'd0);
    chk("rst stalls", stall_cycles, 32'd0);
    chk("rst squash", squash_count, 32'd0);

    // Jump beats branch, target aligned
    run("run");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h83, "dual");
    chk("dual pc",     fif.imem_addr, 32'h80);
    chk("dual state",  {30'd0, fetch_state}, 32'd2);
    chk("dual valid",  {31'd0, fif.id_valid}, 32'd0);
    chk("dual squash", squash_count, PERF ? 32'd1 : 32'd0);

    // PC wraps from the top of the address space
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, "jtop");
    run("wrap");
    chk("wrap pc",   fif.imem_addr,      32'h0);
    chk("wrap pc4",  fif.id_pc_plus4,    32'h0);
    chk("wrap inst", fif.id_instruction, 32'h1FFF_FFFC);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bit r, p, w, b, jj;
      r  = ($urandom_range(0, 39) == 0);
      p  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 3) != 0);
      b  = p && ($urandom_range(0, 5) == 0);
      jj = p && ($urandom_range(0, 7) == 0);
      cycle(r, p, w, b, $urandom, jj, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
